led_scan_mux: RTL
=================

Name: led_scan_mux

Overview:
- Parametrised multiplexed LED/7-seg scan driver. Successor to the fixed 4×8 scanner.
- Generalised in common count, segment width and output polarity.
- Adds frame-synchronous tear-free data latching, inter-slot ghost blanking, PWM brightness control, enable gating and a frame-start strobe.
- Sits between game/score logic and the board LED pins.

Parameters:
- NUM_COM, 4, number of common lines / scan slots (≥1, need not be a power of 2)
- SEG_WIDTH, 8, segment bits per slot
- SCAN_INTERVAL, 100_000, clocks per slot (> BLANK_CYCLES)
- BLANK_CYCLES, 16, clocks at start of each slot with all outputs inactive (≥1)
- BRIGHT_BITS, 4, width of brightness control / PWM counter
- COM_ACTIVE_LOW, 0, 1 = led_com driven active-low
- SEG_ACTIVE_LOW, 0, 1 = led_bit driven active-low

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = scanning; 0 = display dark, counters held in reset
- leds  in  NUM_COM*SEG_WIDTH  segment data; slot k uses bits [k*SEG_WIDTH +: SEG_WIDTH]
- brightness  in  BRIGHT_BITS  duty control; 0 = off, all-ones = full on
- led_bit  out  SEG_WIDTH  segment drive, registered
- led_com  out  NUM_COM  one-hot common drive, registered
- frame_start  out  1  one-cycle pulse when a new frame's data is latched

Behaviour:
- Reset (rst_n=0, async):
  - slot_cnt=0, scan_idx=0, pwm_cnt=0, shadow=0, frame_start=0.
  - led_bit and led_com at inactive level: all 0, or all 1 per the *_ACTIVE_LOW parameter.
  - Release takes effect on the next clk edge.
- Counters, advancing while enable=1:
  - slot_cnt counts 0..SCAN_INTERVAL-1 and wraps.
  - On wrap, scan_idx increments 0..NUM_COM-1 and wraps to 0. Explicit compare, not modulo-2^n.
  - pwm_cnt is a free-running BRIGHT_BITS counter, +1 every clock.
- Shadow latch: in the cycle with slot_cnt==0 and scan_idx==0, leds is copied into shadow and frame_start=1 next cycle. This is the only load point, so a frame never shows mixed old/new data.
- Drive condition (internal `on`) = enable & (slot_cnt ≥ BLANK_CYCLES) & (brightness==all-ones | pwm_cnt < brightness).
- Outputs are registered, with 1-cycle latency from the counters:
  - If `on`: led_com = one-hot bit scan_idx and led_bit = shadow slice scan_idx, each XOR'd with its polarity.
  - Otherwise both are at the inactive level.
- Blanking:
  - Slot boundaries always give ≥ BLANK_CYCLES clocks with everything off. This prevents ghosting.
  - The shadow load falls inside blanking, so new data is first visible at slot_cnt == BLANK_CYCLES.
- enable=0:
  - On the next clock: slot_cnt, scan_idx and pwm_cnt go to 0, outputs go inactive, frame_start=0, and shadow is held.
  - On re-enable, the first active cycle is slot_cnt==0, scan_idx==0, so shadow reloads immediately.
- brightness changes take effect on the next clock; no glitch protection is required.
- NUM_COM=1: led_com is constant active during drive windows and the shadow reloads every slot.
- Reset asserted mid-slot: all state clears immediately and outputs go inactive without waiting for a clock.

Test Plan (NUM_COM=4, SEG_WIDTH=8, SCAN_INTERVAL=10, BLANK_CYCLES=2, BRIGHT_BITS=2, polarities 0 unless stated):
- Reset and basic scan:
  - Stimulus: rst_n=0 then 1, enable=1, brightness=3, leds=32'hA1B2C3D4.
  - Required: slot 0 drives led_com=4'b0001 with led_bit=8'hD4 for 8 clocks after 2 blank clocks, then 4'b0010/8'hC3, 4'b0100/8'hB2, 4'b1000/8'hA1, then repeat. frame_start pulses every 40 clocks.
- Tear-free update:
  - Stimulus: change leds to 32'h11223344 while slot 2 is being driven.
  - Required: slots 2–3 still show 8'hB2/8'hA1; the next frame shows 8'h44, 8'h33, ….
- PWM:
  - brightness=1: within each drive window, on only when pwm_cnt==0, i.e. 1 in 4 clocks.
  - brightness=0: outputs are never active.
- Enable gating:
  - Stimulus: drop enable mid-slot 1 for 5 clocks.
  - Required: outputs go inactive next clock. On re-enable, scanning restarts at slot 0 with 2 blank clocks and frame_start pulses.
- Polarity and non-power-of-2:
  - Stimulus: NUM_COM=3, COM_ACTIVE_LOW=1, SEG_ACTIVE_LOW=1.
  - Required: led_com cycles 3'b110, 3'b101, 3'b011 and is 3'b111 during blanking. led_bit is inverted. scan_idx never reaches 3.
- Async reset mid-slot:
  - Stimulus: assert rst_n=0 between clock edges during slot 2.
  - Required: outputs go inactive immediately and frame_start=0. After release, scanning resumes from slot 0 with shadow=0.

Source files
------------

// File: rtl/led_scan_mux.sv
// led_scan_mux: multiplexed LED / 7-segment scan driver.
// Walks NUM_COM common lines, one slot of SCAN_INTERVAL clocks each. Every
// slot opens with BLANK_CYCLES dark clocks so that the segment pattern of the
// previous common never bleeds into the next one (ghosting). Segment data is
// captured once per frame into a shadow register, so a frame never mixes old
// and new data. Drive windows are PWM-gated by `brightness`.
module led_scan_mux #(
  parameter int NUM_COM        = 4,
  parameter int SEG_WIDTH      = 8,
  parameter int SCAN_INTERVAL  = 100_000,
  parameter int BLANK_CYCLES   = 16,
  parameter int BRIGHT_BITS    = 4,
  parameter int COM_ACTIVE_LOW = 0,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [NUM_COM*SEG_WIDTH-1:0]   leds,
  input  logic [BRIGHT_BITS-1:0]         brightness,
  output logic [SEG_WIDTH-1:0]           led_bit,
  output logic [NUM_COM-1:0]             led_com,
  output logic                           frame_start
);

  localparam int SLOT_W = (SCAN_INTERVAL > 1) ? $clog2(SCAN_INTERVAL) : 1;
  localparam int IDX_W  = (NUM_COM > 1) ? $clog2(NUM_COM) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(SCAN_INTERVAL - 1);
  localparam logic [SLOT_W-1:0] BLANK_START = SLOT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(NUM_COM - 1);

  // Inactive ("off") levels; XOR-ing an active-high pattern with these
  // yields the pin polarity.
  localparam logic                 COM_POL = (COM_ACTIVE_LOW != 0);
  localparam logic                 SEG_POL = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_COM-1:0]   COM_OFF = {NUM_COM{COM_POL}};
  localparam logic [SEG_WIDTH-1:0] SEG_OFF = {SEG_WIDTH{SEG_POL}};

  // State
  logic [SLOT_W-1:0]            slot_cnt_q,    slot_cnt_d;
  logic [IDX_W-1:0]             scan_idx_q,    scan_idx_d;
  logic [BRIGHT_BITS-1:0]       pwm_cnt_q,     pwm_cnt_d;
  logic [NUM_COM*SEG_WIDTH-1:0] shadow_q,      shadow_d;
  logic [SEG_WIDTH-1:0]         led_bit_q,     led_bit_d;
  logic [NUM_COM-1:0]           led_com_q,     led_com_d;
  logic                         frame_start_q, frame_start_d;

  // Decoded helpers
  logic                         drive_on;
  logic                         pwm_on;
  logic [NUM_COM-1:0]           com_onehot;
  logic [SEG_WIDTH-1:0]         seg_slice;

  // Slot / scan / PWM counters; enable=0 parks them all at zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    slot_cnt_d = slot_cnt_q;
    scan_idx_d = scan_idx_q;
    pwm_cnt_d  = pwm_cnt_q;
    if (!enable) begin
      slot_cnt_d = '0;
      scan_idx_d = '0;
      pwm_cnt_d  = '0;
    end else begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      if (slot_cnt_q == SLOT_LAST) begin
        slot_cnt_d = '0;
        // Explicit wrap so non-power-of-2 common counts never overrun.
        scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
      end else begin
        slot_cnt_d = slot_cnt_q + 1'b1;
      end
    end
  end

  // Frame-synchronous shadow load: the only point where new data enters.
  always_comb begin
    frame_start_d = enable && (slot_cnt_q == '0) && (scan_idx_q == '0);
    shadow_d      = frame_start_d ? leds : shadow_q;
  end

  // Drive decision and output patterns for the current slot.
  always_comb begin
    pwm_on   = (&brightness) || (pwm_cnt_q < brightness);
    drive_on = enable && (slot_cnt_q >= BLANK_START) && pwm_on;

    com_onehot = '0;
    for (int k = 0; k < NUM_COM; k++) begin
      com_onehot[k] = (scan_idx_q == IDX_W'(k));
    end
    seg_slice = shadow_q[int'(scan_idx_q)*SEG_WIDTH +: SEG_WIDTH];

    led_com_d = drive_on ? (com_onehot ^ COM_OFF) : COM_OFF;
    led_bit_d = drive_on ? (seg_slice ^ SEG_OFF) : SEG_OFF;
  end

  // State registers; reset drives the pins to their inactive level at once.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (!rst_n) begin
      slot_cnt_q    <= '0;
      scan_idx_q    <= '0;
      pwm_cnt_q     <= '0;
      // NOTE: the shadow store is reset on purpose so a freshly reset board
      // can never flash stale data; it is small enough to live in flops.
      shadow_q      <= '0;
      led_bit_q     <= SEG_OFF;
      led_com_q     <= COM_OFF;
      frame_start_q <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      scan_idx_q    <= scan_idx_d;
      pwm_cnt_q     <= pwm_cnt_d;
      shadow_q      <= shadow_d;
      led_bit_q     <= led_bit_d;
      led_com_q     <= led_com_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign led_bit     = led_bit_q;
  assign led_com     = led_com_q;
  assign frame_start = frame_start_q;

endmodule
